// File: rtl/mul_arbiter_ctrl.sv
// Round-robin front end for a shared combinational multiplier. It latches one request's
// operands, waits MUL_LAT cycles for the product to settle, then holds the result until it is taken.
module mul_arbiter_ctrl #(
  parameter int dataW   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic [dataW-1:0] req0A,
  input  logic [dataW-1:0] req0B,
  input  logic [1:0]       req0Code,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic [dataW-1:0] req1A,
  input  logic [dataW-1:0] req1B,
  input  logic [1:0]       req1Code,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [dataW-1:0] rspData,
  output logic             rspId,
  output logic [dataW-1:0] mulA,
  output logic [dataW-1:0] mulB,
  output logic [1:0]       mulCode,
  input  logic [dataW-1:0] mulOut,
  output logic             busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  generate
    if (MUL_LAT < 1) begin : g_lat_check
      $error("mul_arbiter_ctrl: MUL_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic              last_gnt_reg, last_gnt_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [dataW-1:0]  rsp_data_reg, rsp_data_next;
  logic              rsp_id_reg, rsp_id_next;
  logic [dataW-1:0]  mul_a_reg, mul_a_next;
  logic [dataW-1:0]  mul_b_reg, mul_b_next;
  logic [1:0]        mul_code_reg, mul_code_next;
  logic              grant;
  logic              accept;

  // A tie goes to the port that did not win the last acceptance.
  always_comb begin
    if (req0Valid && req1Valid) grant = ~last_gnt_reg;
    else                        grant = req1Valid;
  end

  assign req0Ready = nReset && (state_reg == IDLE) && !grant;
  assign req1Ready = nReset && (state_reg == IDLE) && grant;
  assign accept    = (req0Valid && req0Ready) || (req1Valid && req1Ready);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg     <= IDLE;
      last_gnt_reg  <= 1'b1;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= 1'b0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      mul_code_reg  <= 2'b00;
    end else begin
      state_reg     <= state_next;
      last_gnt_reg  <= last_gnt_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_id_reg    <= rsp_id_next;
      mul_a_reg     <= mul_a_next;
      mul_b_reg     <= mul_b_next;
      mul_code_reg  <= mul_code_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_gnt_next  = last_gnt_reg;
    cnt_next       = cnt_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_id_next    = rsp_id_reg;
    mul_a_next     = mul_a_reg;
    mul_b_next     = mul_b_reg;
    mul_code_next  = mul_code_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          mul_a_next    = grant ? req1A : req0A;
          mul_b_next    = grant ? req1B : req0B;
          mul_code_next = grant ? req1Code : req0Code;
          rsp_id_next   = grant;
          last_gnt_next = grant;
          cnt_next      = CNT_INIT;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        // cnt==0 means the multiplier has had MUL_LAT full cycles to settle.
        if (cnt_reg == '0) begin
          rsp_data_next  = mulOut;
          rsp_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        if (rspReady) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rspValid = rsp_valid_reg;
  assign rspData  = rsp_data_reg;
  assign rspId    = rsp_id_reg;
  assign mulA     = mul_a_reg;
  assign mulB     = mul_b_reg;
  assign mulCode  = mul_code_reg;
  assign busy     = (state_reg != IDLE);

endmodule
